// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART register-write frame controller.
// Used by uart_frame_ctrl and uart_gap_timer.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        CHK  = 2'd3
    } frame_state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHK  = 2'd1;
    localparam logic [1:0] ERR_ADDR = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam int NUM_REGS = 4;

    // Frame checksum: byte-wise sum of header, address and data, modulo 256.
    function automatic logic [7:0] frame_sum(input logic [7:0] hdr,
                                             input logic [7:0] addr,
                                             input logic [7:0] data);
        return hdr + addr + data;
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Loadable down-counter that flags the last clock of an inter-byte gap window.
// Clear has priority over load; expired is high while the count sits at one.
module uart_gap_timer #(
    parameter int LOAD_VAL = 50_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear,
    input  logic load,
    output logic expired
);

    localparam int CNT_W = $clog2(LOAD_VAL + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(LOAD_VAL);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(1));

endmodule

// File: rtl/uart_frame_ctrl.sv
// Parses HEADER/ADDR/DATA[/CHK] byte frames from a UART receiver into register writes.
// Define UART_FRAME_CHK_EN to require the trailing checksum byte.
module uart_frame_ctrl #(
    parameter int          CLK_FREQ    = 50_000_000,
    parameter int          TIMEOUT_CYC = 50_000,
    parameter logic [7:0]  HEADER      = 8'hA5
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  uart_data,
    input  logic        uart_done,
    output logic        wr_en,
    output logic [1:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic [31:0] cfg_regs,
    output logic        frame_err,
    output logic [1:0]  err_code
);

    import uart_frame_pkg::*;

    frame_state_t state;
    frame_state_t state_next;

    logic       uart_done_q;
    logic       strobe;
    logic       gap_expired;
    logic       timeout;
    logic       timer_clear;
    logic [7:0] addr_q;
    logic       capture_addr;
    logic       commit;
    logic [7:0] commit_data;
    logic       reject;
    logic [1:0] reject_code;
`ifdef UART_FRAME_CHK_EN
    logic [7:0] data_q;
    logic       capture_data;
`endif

    assign strobe      = uart_done & ~uart_done_q;
    // A byte arriving on the expiry cycle keeps the frame alive.
    assign timeout     = gap_expired & ~strobe & (state != IDLE);
    assign timer_clear = (state_next == IDLE);

    uart_gap_timer #(
        .LOAD_VAL (TIMEOUT_CYC)
    ) u_gap_timer (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (timer_clear),
        .load    (strobe),
        .expired (gap_expired)
    );

    always_comb begin
        state_next   = state;
        capture_addr = 1'b0;
        commit       = 1'b0;
        commit_data  = uart_data;
        reject       = 1'b0;
        reject_code  = ERR_NONE;
`ifdef UART_FRAME_CHK_EN
        capture_data = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (strobe && uart_data == HEADER) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (strobe) begin
                    capture_addr = 1'b1;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (strobe) begin
`ifdef UART_FRAME_CHK_EN
                    capture_data = 1'b1;
                    state_next   = CHK;
`else
                    state_next = IDLE;
                    if (addr_q < 8'(NUM_REGS)) begin
                        commit = 1'b1;
                    end else begin
                        reject      = 1'b1;
                        reject_code = ERR_ADDR;
                    end
`endif
                end
            end
`ifdef UART_FRAME_CHK_EN
            CHK: begin
                commit_data = data_q;
                if (strobe) begin
                    state_next = IDLE;
                    if (uart_data != frame_sum(HEADER, addr_q, data_q)) begin
                        reject      = 1'b1;
                        reject_code = ERR_CHK;
                    end else if (addr_q >= 8'(NUM_REGS)) begin
                        reject      = 1'b1;
                        reject_code = ERR_ADDR;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
        if (timeout) begin
            state_next  = IDLE;
            reject      = 1'b1;
            reject_code = ERR_TMO;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            uart_done_q <= 1'b0;
            addr_q      <= '0;
`ifdef UART_FRAME_CHK_EN
            data_q      <= '0;
`endif
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            cfg_regs    <= '0;
            frame_err   <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            state       <= state_next;
            uart_done_q <= uart_done;
            wr_en       <= commit;
            frame_err   <= reject;
            if (capture_addr) begin
                addr_q <= uart_data;
            end
`ifdef UART_FRAME_CHK_EN
            if (capture_data) begin
                data_q <= uart_data;
            end
`endif
            // Register bank and write port update on the same edge as the wr_en pulse.
            if (commit) begin
                wr_addr                                <= addr_q[1:0];
                wr_data                                <= commit_data;
                cfg_regs[{addr_q[1:0], 3'b000} +: 8]   <= commit_data;
            end
            if (reject) begin
                err_code <= reject_code;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: directed frames plus a randomized byte stream,
// compared against a frame-level reference model (honours UART_FRAME_CHK_EN).
module tb_uart_frame_ctrl;

    localparam int         T   = 40;
    localparam logic [7:0] HDR = 8'hA5;
`ifdef UART_FRAME_CHK_EN
    localparam int FRAME_LEN = 4;
    localparam bit CHK_EN    = 1'b1;
`else
    localparam int FRAME_LEN = 3;
    localparam bit CHK_EN    = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [7:0]  uart_data;
    logic        uart_done;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [31:0] cfg_regs;
    logic        frame_err;
    logic [1:0]  err_code;

    uart_frame_ctrl #(
        .CLK_FREQ    (50_000_000),
        .TIMEOUT_CYC (T),
        .HEADER      (HDR)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .uart_data (uart_data),
        .uart_done (uart_done),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cfg_regs  (cfg_regs),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  overlap_cnt = 0;
    int  errors = 0;
    int  checks = 0;

    // Observed output pulses, time-stamped with the cycle they appear in.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (wr_en)     obs_q.push_back('{1, cyc, {6'b0, wr_addr}, wr_data});
            if (frame_err) obs_q.push_back('{2, cyc, {6'b0, err_code}, 8'h00});
            if (wr_en && frame_err) overlap_cnt++;
        end
    end

    // Reference model state: bytes of the frame in progress and the expected bank.
    logic [7:0] frame_buf[$];
    int         last_strobe = 0;
    logic [7:0] m_regs[4];
    logic [1:0] m_err;
    logic [1:0] m_wr_addr;
    logic [7:0] m_wr_data;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        frame_buf.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_err     = 2'd0;
        m_wr_addr = 2'd0;
        m_wr_data = 8'h00;
    endtask

    task automatic model_advance(input int now);
        if (frame_buf.size() != 0 && now > last_strobe + T) begin
            exp_q.push_back('{2, last_strobe + T + 1, 8'd3, 8'h00});
            m_err = 2'd3;
            frame_buf.delete();
        end
    endtask

    task automatic model_byte(input int c, input logic [7:0] b);
        logic [7:0] sum;
        model_advance(c);
        if (frame_buf.size() == 0) begin
            if (b == HDR) begin
                frame_buf.push_back(b);
                last_strobe = c;
            end
        end else begin
            frame_buf.push_back(b);
            last_strobe = c;
            if (frame_buf.size() == FRAME_LEN) begin
                sum = frame_buf[0] + frame_buf[1] + frame_buf[2];
                if (CHK_EN && frame_buf[3] != sum) begin
                    exp_q.push_back('{2, c + 1, 8'd1, 8'h00});
                    m_err = 2'd1;
                end else if (frame_buf[1] >= 8'd4) begin
                    exp_q.push_back('{2, c + 1, 8'd2, 8'h00});
                    m_err = 2'd2;
                end else begin
                    exp_q.push_back('{1, c + 1, frame_buf[1], frame_buf[2]});
                    m_regs[frame_buf[1][1:0]] = frame_buf[2];
                    m_wr_addr = frame_buf[1][1:0];
                    m_wr_data = frame_buf[2];
                end
                frame_buf.delete();
            end
        end
    endtask

    // Present one byte: uart_done high for 'width' clocks, then low for 'low' clocks.
    task automatic applyStimulus(input logic [7:0] b, input int width, input int low);
        uart_data = b;
        uart_done = 1'b1;
        model_byte(cyc, b);
        repeat (width) @(posedge sys_clk);
        #1;
        uart_done = 1'b0;
        uart_data = 8'($urandom);
        repeat (low) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, input int width);
        applyStimulus(b0, width, 2);
        applyStimulus(b1, width, 2);
        applyStimulus(b2, width, 2);
        applyStimulus(b3, width, 2);
    endtask

    task automatic settle();
        repeat (T + 5) @(posedge sys_clk);
        #1;
        model_advance(cyc);
        repeat (2) @(posedge sys_clk);
        #1;
    endtask

    task automatic compare_events(input string tag);
        int n;
        checkOutput({tag, "_evcount"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_evcyc"}, obs_q[i].cyc, exp_q[i].cyc);
            checkOutput({tag, "_evbody"}, {8'(obs_q[i].kind), obs_q[i].a, obs_q[i].d},
                                          {8'(exp_q[i].kind), exp_q[i].a, exp_q[i].d});
        end
        obs_q.delete();
        exp_q.delete();
        checkOutput({tag, "_regs"}, cfg_regs, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
        checkOutput({tag, "_errcode"}, err_code, m_err);
        checkOutput({tag, "_wraddr"}, wr_addr, m_wr_addr);
        checkOutput({tag, "_wrdata"}, wr_data, m_wr_data);
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_wr_en"}, wr_en, 1'b0);
        checkOutput({tag, "_wr_addr"}, wr_addr, 2'd0);
        checkOutput({tag, "_wr_data"}, wr_data, 8'h00);
        checkOutput({tag, "_cfg_regs"}, cfg_regs, 32'h0);
        checkOutput({tag, "_frame_err"}, frame_err, 1'b0);
        checkOutput({tag, "_err_code"}, err_code, 2'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] a, d, s;
        int         kind, w;

        sys_rst   = 1'b1;
        uart_done = 1'b0;
        uart_data = 8'h00;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        check_reset_outputs("init");
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;

        // Long uart_done levels still give one write.
        send4(8'hA5, 8'h02, 8'h3C, 8'hE3, 3);
        settle();
        compare_events("req025");
        checkOutput("req025_reg2", cfg_regs[23:16], 8'h3C);

        send4(8'hA5, 8'h01, 8'h10, 8'h00, 1);
        settle();
        compare_events("req026");

        send4(8'hA5, 8'h07, 8'h11, 8'hBD, 2);
        settle();
        compare_events("req027");

        // Gap of exactly T clocks between strobes survives; T+1 times out.
        applyStimulus(8'hA5, 1, 1);
        applyStimulus(8'h02, 1, T - 1);
        applyStimulus(8'h77, 1, 1);
        applyStimulus(8'h5E, 1, 1);
        settle();
        compare_events("gap_edge");

        applyStimulus(8'hA5, 1, 1);
        applyStimulus(8'h01, 1, T);
        send4(8'hA5, 8'h01, 8'h55, 8'hFB, 1);
        settle();
        compare_events("req028");
        checkOutput("req028_reg1", cfg_regs[15:8], 8'h55);

        applyStimulus(8'h00, 1, 1);
        applyStimulus(8'h5A, 1, 1);
        send4(8'hA5, 8'h00, 8'hA5, 8'h4A, 1);
        settle();
        compare_events("req029");
        checkOutput("req029_reg0", cfg_regs[7:0], 8'hA5);

        applyStimulus(8'hA5, 1, 1);
        applyStimulus(8'h03, 1, 1);
        compare_events("pre_rst");
        sys_rst = 1'b1;
        #2;
        check_reset_outputs("midrst");
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        send4(8'hA5, 8'h03, 8'h01, 8'hA9, 1);
        settle();
        compare_events("req030");
        checkOutput("req030_reg3", cfg_regs[31:24], 8'h01);

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 4);
            w    = $urandom_range(1, 4);
            a    = (kind == 2) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
            d    = 8'($urandom);
            s    = HDR + a + d;
            if (kind == 1) s = s + 8'($urandom_range(1, 255));
            case (kind)
                3: begin
                    for (int k = 0; k < 3; k++) applyStimulus(8'($urandom), w, $urandom_range(1, 3));
                end
                4: begin
                    applyStimulus(HDR, w, $urandom_range(1, 3));
                    applyStimulus(a, w, T + $urandom_range(0, 3));
                end
                default: begin
                    applyStimulus(HDR, w, $urandom_range(1, 3));
                    applyStimulus(a, w, $urandom_range(1, 3));
                    applyStimulus(d, w, $urandom_range(1, 3));
                    applyStimulus(s, w, $urandom_range(1, 3));
                end
            endcase
            if (it % 8 == 7) begin
                settle();
                compare_events("rand");
            end
        end

        settle();
        compare_events("final");
        checkOutput("excl", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning system clock frequency in Hz (documentation only).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50_000, meaning the maximum idle gap in clocks between bytes of one frame.
REQ-003 SHALL have parameter HEADER, default 8'hA5, meaning the frame start byte.
REQ-004 SHALL have ports, one per line:
  sys_clk  in  1  sole clock, rising edge.
  sys_rst  in  1  asynchronous, active-high reset.
  uart_data  in  8  received byte from the UART receiver.
  uart_done  in  1  byte-valid level from the receiver; may stay high for several cycles per byte.
  wr_en  out  1  one-cycle pulse, register write committed.
  wr_addr  out  2  address of the committed write.
  wr_data  out  8  data of the committed write.
  cfg_regs  out  32  register bank, reg N on bits [8N+7:8N].
  frame_err  out  1  one-cycle pulse, frame rejected.
  err_code  out  2  cause of the last rejection: 1 checksum, 2 address, 3 timeout; held until the next rejection.
REQ-005 SHALL be decided as: one clock; reset is asynchronous and active-high.

Function
REQ-006 SHALL register uart_done once and derive byte strobe = uart_done & ~uart_done_q, so each byte is accepted exactly once regardless of uart_done width.
REQ-007 SHALL implement FSM states IDLE, ADDR, DATA, CHK, with transitions taken only on the strobe cycle.
REQ-008 SHALL transition IDLE->ADDR on a strobe with uart_data==HEADER; any other byte in IDLE is silently dropped, with no frame_err.
REQ-009 SHALL capture the address on ADDR->DATA and the data on DATA->CHK.
REQ-010 SHALL, in CHK on strobe, compare uart_data with (HEADER+addr+data) mod 256, then return to IDLE.
REQ-011 SHALL, one cycle after an accepted final strobe, pulse wr_en and present wr_addr/wr_data; cfg_regs SHALL update on that same edge.
REQ-012 SHALL accept only addr<4: a frame with a valid checksum but addr>=4 causes no write, frame_err pulse and err_code=2.
REQ-013 SHALL, on a checksum mismatch, cause no write, frame_err pulse one cycle after the strobe and err_code=1.
REQ-014 SHALL, in a non-IDLE state, reload the gap counter on each strobe; after TIMEOUT_CYC clocks without a strobe it SHALL return to IDLE, pulse frame_err and set err_code=3.
REQ-015 SHALL give the strobe priority when a strobe and the timeout occur in the same cycle (no timeout error).
REQ-016 SHALL treat a HEADER value received mid-frame as ordinary payload (no resync).
REQ-017 SHALL keep wr_en and frame_err mutually exclusive; wr_addr/wr_data hold their last values between writes.
REQ-018 SHALL accept back-to-back frames with no dead cycles beyond REQ-011.

Reset
REQ-019 SHALL, while sys_rst is high, force state IDLE, gap counter 0, uart_done_q 0, wr_en 0, wr_addr 0, wr_data 0, cfg_regs 0, frame_err 0, err_code 0.
REQ-020 SHALL discard a partial frame when reset asserts mid-frame; the first byte after release SHALL be evaluated in IDLE.

Configuration
REQ-021 SHALL, with macro UART_FRAME_CHK_EN defined, use the 4-byte frame HEADER, ADDR, DATA, CHK.
REQ-022 SHALL, without UART_FRAME_CHK_EN, omit state CHK, commit from DATA on strobe, and never produce err_code=1.

Structure
REQ-023 SHALL take the following from package uart_frame_pkg:
  - FSM state enum.
  - Error code constants (ERR_NONE, ERR_CHK, ERR_ADDR, ERR_TMO).
  - NUM_REGS=4.
REQ-024 SHALL instantiate one sub-module, uart_gap_timer (loadable down-counter with an expiry flag), for REQ-014.

Verification
REQ-025 SHALL cover: bytes A5 02 3C E3, uart_done held 3 cycles each -> single wr_en, wr_addr=2, wr_data=3C, cfg_regs[23:16]=3C.
REQ-026 SHALL cover: bytes A5 01 10 00 -> frame_err, err_code=1, cfg_regs unchanged, no wr_en.
REQ-027 SHALL cover: bytes A5 07 11 BD -> frame_err, err_code=2, no write.
REQ-028 SHALL cover: A5 01 followed by a gap of TIMEOUT_CYC clocks -> frame_err, err_code=3; then A5 01 55 FB -> write reg1=55.
REQ-029 SHALL cover: bytes 00 5A A5 00 A5 4A -> first two dropped silently; write reg0=A5 (mid-frame A5 is payload).
REQ-030 SHALL cover: sys_rst pulsed after A5 03 -> all outputs 0; A5 03 01 A9 afterwards -> write reg3=01.
